// File: rtl/mio_bus_ctrl.sv
// mio_bus_ctrl: sequences one CPU memory access at a time onto either a
// synchronous RAM port or a handshaked IO port, with alignment/size checks,
// an IO timeout and a one-cycle completion pulse back to the CPU.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   cpu_req_i/we_i/size_i      CPU request, held stable until mio_ready_o
//   cpu_addr_i/cpu_wdata_i     byte address, right-aligned write data
//   cpu_rdata_o                read data, extended per access size
//   mio_ready_o, bus_err_o     completion pulse, error flag on that pulse
//   ram_en_o/we_o/addr_o/din_o synchronous RAM command port
//   ram_dout_i                 RAM read data, one cycle after ram_en_o
//   io_req_o/we_o/addr_o/wdata_o  IO request, held until io_ack_i
//   io_rdata_i, io_ack_i       IO read data and acknowledge
//   state_out_o                current state code, for test
module mio_bus_ctrl #(
  parameter logic [31:0] IO_BASE = 32'hF000_0000,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [1:0]  cpu_size_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic [31:0] cpu_rdata_o,
  output logic        mio_ready_o,
  output logic        bus_err_o,
  output logic        ram_en_o,
  output logic [3:0]  ram_we_o,
  output logic [29:0] ram_addr_o,
  output logic [31:0] ram_din_o,
  input  logic [31:0] ram_dout_i,
  output logic        io_req_o,
  output logic        io_we_o,
  output logic [31:0] io_addr_o,
  output logic [31:0] io_wdata_o,
  input  logic [31:0] io_rdata_i,
  input  logic        io_ack_i,
  output logic [2:0]  state_out_o
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 32'd1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RAM_ACC = 3'd1;
  localparam logic [2:0] S_RAM_RD  = 3'd2;
  localparam logic [2:0] S_IO_REQ  = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_ERR     = 3'd5;

  localparam logic [1:0] SZ_WORD   = 2'b00;
  localparam logic [1:0] SZ_HALF_S = 2'b01;
  localparam logic [1:0] SZ_RSVD   = 2'b11;

  logic [2:0]       state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [1:0]       size_q, size_d;
  logic             we_q, we_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             ram_en_q, ram_en_d;
  logic [3:0]       ram_we_q, ram_we_d;
  logic             io_req_q, io_req_d;
  logic             ready_q, ready_d;
  logic             berr_q, berr_d;
  logic             bad_req_c;

  // Pick the addressed half (or whole word) and extend to 32 bits.
  function automatic logic [31:0] extract(input logic [31:0] v,
                                          input logic [1:0]  sz,
                                          input logic        hi);
    logic [15:0] h;
    h = hi ? v[31:16] : v[15:0];
    case (sz)
      SZ_WORD:   extract = v;
      SZ_HALF_S: extract = {{16{h[15]}}, h};
      default:   extract = {16'h0000, h};
    endcase
  endfunction

  // Reserved size or an address not aligned to the access size.
  assign bad_req_c = (cpu_size_i == SZ_RSVD) ||
                     ((cpu_size_i == SZ_WORD) && (cpu_addr_i[1:0] != 2'b00)) ||
                     ((cpu_size_i != SZ_WORD) && cpu_addr_i[0]);

  // State, request latches and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      we_q     <= 1'b0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      ram_en_q <= 1'b0;
      ram_we_q <= '0;
      io_req_q <= 1'b0;
      ready_q  <= 1'b0;
      berr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      we_q     <= we_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      ram_en_q <= ram_en_d;
      ram_we_q <= ram_we_d;
      io_req_q <= io_req_d;
      ready_q  <= ready_d;
      berr_q   <= berr_d;
    end
  end

  // Next state, latches, timeout counter and read-data capture.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_req_i) begin
          addr_d  = cpu_addr_i;
          wdata_d = cpu_wdata_i;
          size_d  = cpu_size_i;
          we_d    = cpu_we_i;
          if (bad_req_c) begin
            state_d = S_ERR;
          end else if (cpu_addr_i >= IO_BASE) begin
            state_d = S_IO_REQ;
            cnt_d   = '0;
          end else begin
            state_d = S_RAM_ACC;
          end
        end
      end
      S_RAM_ACC: state_d = we_q ? S_DONE : S_RAM_RD;
      S_RAM_RD: begin
        rdata_d = extract(ram_dout_i, size_q, addr_q[1]);
        state_d = S_DONE;
      end
      S_IO_REQ: begin
        // An ack in the final allowed cycle still completes normally.
        if (io_ack_i) begin
          if (!we_q) rdata_d = extract(io_rdata_i, size_q, addr_q[1]);
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_ERR) rdata_d = '0;
  end

  // Strobes for the coming cycle, decoded from the next state so they register
  // alongside it.
  always_comb begin
    ram_en_d = (state_d == S_RAM_ACC);
    ram_we_d = 4'b0000;
    io_req_d = (state_d == S_IO_REQ);
    ready_d  = (state_d == S_DONE) || (state_d == S_ERR);
    berr_d   = (state_d == S_ERR);
    if (ram_en_d && we_d) begin
      if (size_d == SZ_WORD)  ram_we_d = 4'b1111;
      else if (addr_d[1])     ram_we_d = 4'b1100;
      else                    ram_we_d = 4'b0011;
    end
  end

  assign cpu_rdata_o = rdata_q;
  assign mio_ready_o = ready_q;
  assign bus_err_o   = berr_q;
  assign ram_en_o    = ram_en_q;
  assign ram_we_o    = ram_we_q;
  assign ram_addr_o  = addr_q[31:2];
  assign ram_din_o   = (size_q == SZ_WORD) ? wdata_q : {wdata_q[15:0], wdata_q[15:0]};
  assign io_req_o    = io_req_q;
  assign io_we_o     = we_q;
  assign io_addr_o   = addr_q;
  assign io_wdata_o  = wdata_q;
  assign state_out_o = state_q;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Testbench for mio_bus_ctrl: directed accesses with a per-cycle expected
// timeline derived from access type, plus literal checks on key results.
module tb_mio_bus_ctrl;

  localparam logic [31:0] IO_BASE = 32'hF000_0000;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        mio_ready, bus_err, ram_en;
  logic [3:0]  ram_we;
  logic [29:0] ram_addr;
  logic [31:0] ram_din, ram_dout;
  logic        io_req, io_we;
  logic [31:0] io_addr, io_wdata, io_rdata;
  logic        io_ack;
  logic [2:0]  state_out;

  mio_bus_ctrl #(.IO_BASE(IO_BASE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_size_i(cpu_size),
    .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata),
    .mio_ready_o(mio_ready), .bus_err_o(bus_err),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_din_o(ram_din), .ram_dout_i(ram_dout),
    .io_req_o(io_req), .io_we_o(io_we), .io_addr_o(io_addr),
    .io_wdata_o(io_wdata), .io_rdata_i(io_rdata), .io_ack_i(io_ack),
    .state_out_o(state_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int req_cyc = 0;
  int ready_cyc = 0;
  int ready_cnt = 0;
  int ram_en_cnt = 0;
  logic chk_en = 1'b0;
  logic last_berr = 1'b0;
  logic [29:0] last_ram_addr = '0;
  logic [3:0]  last_ram_we = '0;
  logic [31:0] last_ram_din = '0;

  // Expected outputs for the current cycle.
  logic        exp_ready, exp_berr, exp_ram_en, exp_io_req, exp_we;
  logic [3:0]  exp_ram_we;
  logic [2:0]  exp_state;
  logic [31:0] exp_rdata, exp_addr, exp_wdata, exp_din;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  // Per-cycle comparison against the model, plus observation records.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("mio_ready", 32'(mio_ready), 32'(exp_ready));
      cmp("bus_err",   32'(bus_err),   32'(exp_berr));
      cmp("ram_en",    32'(ram_en),    32'(exp_ram_en));
      cmp("ram_we",    32'(ram_we),    32'(exp_ram_we));
      cmp("io_req",    32'(io_req),    32'(exp_io_req));
      cmp("state_out", 32'(state_out), 32'(exp_state));
      cmp("cpu_rdata", cpu_rdata,      exp_rdata);
      if (exp_ram_en) begin
        cmp("ram_addr", 32'(ram_addr), exp_addr >> 2);
        if (exp_ram_we != 4'b0000) cmp("ram_din", ram_din, exp_din);
      end
      if (exp_io_req) begin
        cmp("io_addr",  io_addr,      exp_addr);
        cmp("io_we",    32'(io_we),   32'(exp_we));
        cmp("io_wdata", io_wdata,     exp_wdata);
      end
    end
    if (mio_ready) begin
      ready_cyc <= cyc;
      ready_cnt <= ready_cnt + 1;
      last_berr <= bus_err;
    end
    if (ram_en) begin
      ram_en_cnt    <= ram_en_cnt + 1;
      last_ram_addr <= ram_addr;
      last_ram_we   <= ram_we;
      last_ram_din  <= ram_din;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_exp();
    exp_ready  = 1'b0;
    exp_berr   = 1'b0;
    exp_ram_en = 1'b0;
    exp_ram_we = 4'b0000;
    exp_io_req = 1'b0;
    exp_state  = 3'd0;
  endtask

  // Half-word/word extraction from the access rules.
  function automatic logic [31:0] model_extract(input logic [31:0] v, input logic [1:0] sz,
                                                input logic [31:0] a);
    logic [31:0] h;
    if (sz == 2'b00) return v;
    h = ((a & 32'h2) != 0) ? (v >> 16) : (v & 32'h0000_FFFF);
    if (sz == 2'b01 && h >= 32'h0000_8000) h = h | 32'hFFFF_0000;
    return h;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      clear_exp();
      cpu_req = 1'b0;
      step();
    end
  endtask

  // One full access; ack_wait = IO cycles without ack before the ack cycle.
  task automatic run_txn(input logic we, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdv,
                         input int ack_wait, input bit drop_req);
    bit err, io, berr;
    int done_t;
    logic [31:0] new_rdata;
    err = (size == 2'b11) || (size == 2'b00 && (addr & 32'h3) != 0) ||
          (size != 2'b00 && (addr & 32'h1) != 0);
    io  = addr >= IO_BASE;
    exp_addr  = addr;
    exp_we    = we;
    exp_wdata = wdata;
    exp_din   = (size == 2'b00) ? wdata : ((wdata & 32'hFFFF) * 32'h0001_0001);
    berr = 1'b0;
    new_rdata = exp_rdata;
    if (err) begin
      done_t = 1; berr = 1'b1; new_rdata = '0;
    end else if (!io) begin
      done_t = we ? 2 : 3;
      if (!we) new_rdata = model_extract(rdv, size, addr);
    end else if (ack_wait < TIMEOUT) begin
      done_t = ack_wait + 2;
      if (!we) new_rdata = model_extract(rdv, size, addr);
    end else begin
      done_t = TIMEOUT + 1; berr = 1'b1; new_rdata = '0;
    end
    // Request cycle: controller is idle and samples the request at its end.
    clear_exp();
    cpu_req = 1'b1; cpu_we = we; cpu_size = size; cpu_addr = addr; cpu_wdata = wdata;
    ram_dout = 32'hA5A5_0F0F; io_rdata = 32'h5A5A_5A5A; io_ack = 1'b0;
    req_cyc = cyc;
    step();
    for (int t = 1; t <= done_t; t++) begin
      clear_exp();
      if (drop_req) cpu_req = 1'b0;
      ram_dout = 32'hA5A5_0F0F;
      io_ack   = 1'b0;
      io_rdata = 32'h5A5A_5A5A;
      if (t == done_t) begin
        exp_ready = 1'b1;
        exp_berr  = berr;
        exp_rdata = new_rdata;
        exp_state = berr ? 3'd5 : 3'd4;
      end else if (io) begin
        exp_io_req = 1'b1;
        exp_state  = 3'd3;
        if (t == ack_wait + 1) begin
          io_ack = 1'b1;
          io_rdata = rdv;
        end
      end else if (t == 1) begin
        exp_ram_en = 1'b1;
        exp_state  = 3'd1;
        if (we) exp_ram_we = (size == 2'b00) ? 4'hF : (((addr & 32'h2) != 0) ? 4'hC : 4'h3);
      end else begin
        exp_state = 3'd2;
        ram_dout  = rdv;
      end
      step();
    end
    io_ack = 1'b0;
  endtask

  int en_before, rdy_before;

  initial begin
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_size = 2'b00; cpu_addr = '0; cpu_wdata = '0;
    ram_dout = '0; io_rdata = '0; io_ack = 1'b0;
    clear_exp();
    exp_rdata = '0; exp_addr = '0; exp_we = 1'b0; exp_wdata = '0; exp_din = '0;
    chk_en = 1'b1;
    step();
    cmp("rst_state", 32'(state_out), 32'd0);
    cmp("rst_rdata", cpu_rdata, 32'h0);
    cmp("rst_io_req", 32'(io_req), 32'd0);
    step();
    rst = 1'b0;
    idle(2);

    // Word read at 0x10.
    run_txn(1'b0, 2'b00, 32'h0000_0010, 32'h0, 32'h1234_5678, 0, 1'b0);
    cmp("w_rd_rdata", cpu_rdata, 32'h1234_5678);
    cmp("w_rd_addr", 32'(last_ram_addr), 32'h4);
    cmp("w_rd_lat", 32'(ready_cyc - req_cyc), 32'd3);
    idle(1);

    // Half reads, signed and unsigned, upper half.
    run_txn(1'b0, 2'b01, 32'h0000_0012, 32'h0, 32'h8001_7FFF, 0, 1'b0);
    cmp("hs_rdata", cpu_rdata, 32'hFFFF_8001);
    run_txn(1'b0, 2'b10, 32'h0000_0012, 32'h0, 32'h8001_7FFF, 0, 1'b0);
    cmp("hu_rdata", cpu_rdata, 32'h0000_8001);
    run_txn(1'b0, 2'b01, 32'h0000_0010, 32'h0, 32'h8001_7FFF, 0, 1'b0);
    cmp("hs_lo_rdata", cpu_rdata, 32'h0000_7FFF);
    idle(1);

    // Half write at 0x6, then word write.
    run_txn(1'b1, 2'b10, 32'h0000_0006, 32'h0000_ABCD, 32'h0, 0, 1'b0);
    cmp("hw_we", 32'(last_ram_we), 32'hC);
    cmp("hw_din", last_ram_din, 32'hABCD_ABCD);
    cmp("hw_lat", 32'(ready_cyc - req_cyc), 32'd2);
    cmp("hw_rdata_kept", cpu_rdata, 32'h0000_7FFF);
    run_txn(1'b1, 2'b01, 32'h0000_0104, 32'h1111_2222, 32'h0, 0, 1'b0);
    run_txn(1'b1, 2'b00, 32'h0000_0100, 32'hCAFE_F00D, 32'h0, 0, 1'b0);
    cmp("ww_we", 32'(last_ram_we), 32'hF);
    idle(1);

    // Misaligned word read, reserved size, odd half address.
    en_before = ram_en_cnt;
    run_txn(1'b0, 2'b00, 32'h0000_0002, 32'h0, 32'h1234_5678, 0, 1'b0);
    cmp("mis_berr", 32'(last_berr), 32'd1);
    cmp("mis_lat", 32'(ready_cyc - req_cyc), 32'd1);
    cmp("mis_rdata", cpu_rdata, 32'h0);
    run_txn(1'b1, 2'b11, 32'h0000_0020, 32'h5, 32'h0, 0, 1'b0);
    run_txn(1'b0, 2'b10, 32'hF000_0003, 32'h0, 32'h0, 0, 1'b0);
    cmp("err_no_ram_en", 32'(ram_en_cnt - en_before), 32'd0);
    idle(1);

    // IO read with ack after 3 waits; last RAM address below IO_BASE.
    run_txn(1'b0, 2'b00, 32'hF000_0000, 32'h0, 32'hDEAD_BEEF, 3, 1'b0);
    cmp("io_rdata", cpu_rdata, 32'hDEAD_BEEF);
    cmp("io_lat", 32'(ready_cyc - req_cyc), 32'd5);
    cmp("io_berr", 32'(last_berr), 32'd0);
    run_txn(1'b0, 2'b00, 32'hEFFF_FFFC, 32'h0, 32'h0BAD_F00D, 0, 1'b0);
    cmp("below_io_rdata", cpu_rdata, 32'h0BAD_F00D);
    run_txn(1'b1, 2'b00, 32'hF000_1000, 32'h7777_8888, 32'h0, 0, 1'b0);
    run_txn(1'b0, 2'b01, 32'hF000_0002, 32'h0, 32'h9000_0001, 1, 1'b0);
    cmp("io_hs_rdata", cpu_rdata, 32'hFFFF_9000);
    idle(1);

    // Timeout, and ack exactly on the last allowed cycle.
    run_txn(1'b0, 2'b00, 32'hF000_0010, 32'h0, 32'h1, 255, 1'b0);
    cmp("tmo_berr", 32'(last_berr), 32'd1);
    cmp("tmo_lat", 32'(ready_cyc - req_cyc), 32'd17);
    cmp("tmo_rdata", cpu_rdata, 32'h0);
    run_txn(1'b0, 2'b00, 32'hF000_0010, 32'h0, 32'h2468_ACE0, TIMEOUT - 1, 1'b0);
    cmp("late_ack_berr", 32'(last_berr), 32'd0);
    cmp("late_ack_rdata", cpu_rdata, 32'h2468_ACE0);
    idle(1);

    // Request dropped mid-access still completes; back-to-back accesses.
    run_txn(1'b0, 2'b00, 32'h0000_0040, 32'h0, 32'h1357_9BDF, 0, 1'b1);
    run_txn(1'b0, 2'b00, 32'h0000_0044, 32'h0, 32'h0000_0042, 0, 1'b0);
    run_txn(1'b1, 2'b00, 32'h0000_0048, 32'h4242_4242, 32'h0, 0, 1'b0);
    cmp("b2b_rdata", cpu_rdata, 32'h0000_0042);
    idle(1);

    // Reset during an IO access aborts it.
    rdy_before = ready_cnt;
    clear_exp();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'b00; cpu_addr = 32'hF000_0000; cpu_wdata = '0;
    exp_addr = cpu_addr; exp_we = 1'b0; exp_wdata = '0;
    step();
    for (int t = 1; t <= 2; t++) begin
      clear_exp();
      exp_io_req = 1'b1;
      exp_state  = 3'd3;
      step();
    end
    rst = 1'b1;
    cpu_req = 1'b0;
    clear_exp();
    exp_rdata = '0;
    #1;
    cmp("rst_mid_io_req", 32'(io_req), 32'd0);
    cmp("rst_mid_state", 32'(state_out), 32'd0);
    step();
    rst = 1'b0;
    idle(2);
    cmp("rst_no_ready", 32'(ready_cnt - rdy_before), 32'd0);
    run_txn(1'b0, 2'b00, 32'h0000_0010, 32'h0, 32'h1234_5678, 0, 1'b0);
    cmp("post_rst_rdata", cpu_rdata, 32'h1234_5678);
    idle(2);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mio_bus_ctrl.md
MIO_BUS_CTRL -- requirements
Module: mio_bus_ctrl

Interface
REQ-001 Parameter IO_BASE, default 32'hF000_0000; cpu_addr >= IO_BASE selects IO, otherwise RAM.
REQ-002 Parameter TIMEOUT, default 16; maximum IO_REQ cycles before bus error, legal range 2..255.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 cpu_req  in  1  CPU access request (CPU_MIO); held stable with addr/data/size/we until mio_ready.
REQ-006 cpu_we  in  1  1 = write, 0 = read.
REQ-007 cpu_size  in  2  00 word, 01 half signed, 10 half unsigned, 11 reserved.
REQ-008 cpu_addr  in  32  byte address.
REQ-009 cpu_wdata  in  32  write data, right-aligned.
REQ-010 cpu_rdata  out  32  registered read data, extended per cpu_size.
REQ-011 mio_ready  out  1  one-cycle completion pulse (MIO_ready to controller).
REQ-012 bus_err  out  1  one-cycle pulse, coincident with mio_ready, on misalignment, reserved size or timeout.
REQ-013 ram_en / ram_we / ram_addr / ram_din  out  1 / 4 / 30 / 32  synchronous RAM port; ram_addr = word address cpu_addr[31:2].
REQ-014 ram_dout  in  32  RAM read data, valid the cycle after ram_en.
REQ-015 io_req / io_we / io_addr / io_wdata  out  1 / 1 / 32 / 32  IO port, io_req held until io_ack.
REQ-016 io_rdata, io_ack  in  32, 1  IO read data, valid when io_ack=1.
REQ-017 state_out  out  3  current state encoding, for test.

Function
REQ-018 States, encoding: IDLE=0, RAM_ACC=1, RAM_RD=2, IO_REQ=3, DONE=4, ERR=5; codes 6/7 return to IDLE next cycle.
REQ-019 IDLE: when cpu_req=1, latch addr, wdata, size and we; the next state is ERR if size=11, or size=word with addr[1:0]!=0, or a half-word size with addr[0]=1; otherwise IO_REQ if addr>=IO_BASE; otherwise RAM_ACC.
REQ-020 RAM_ACC: ram_en=1 for exactly one cycle; write goes to DONE, read goes to RAM_RD.
REQ-021 Word write: ram_we=1111, ram_din=wdata.
REQ-022 Half write: ram_we=0011 with addr[1]=0 or 1100 with addr[1]=1; ram_din={wdata[15:0],wdata[15:0]}.
REQ-023 RAM_RD: capture ram_dout into cpu_rdata: word as-is; half selects [15:0] (addr[1]=0) or [31:16], sign-extended (01) or zero-extended (10); then DONE.
REQ-024 IO_REQ: io_req=1 with latched io_addr/io_we/io_wdata; on io_ack, capture io_rdata with the same extraction as REQ-023 (reads only) and go to DONE.
REQ-025 Timeout counter: cleared on IO_REQ entry, increments each IO_REQ cycle without io_ack; reaching TIMEOUT goes to ERR with io_req dropped.
REQ-026 io_ack and timeout in the same cycle: ack wins.
REQ-027 DONE: mio_ready=1 for one cycle, bus_err=0, then IDLE.
REQ-028 ERR: mio_ready=1 and bus_err=1 for one cycle, cpu_rdata=0, no RAM or IO strobe ever issued for the access, then IDLE.
REQ-029 Latency from the req-sampling edge to mio_ready: RAM read 3 cycles, RAM write 2, IO ack-latency+2, error 1.
REQ-030 cpu_req still high in IDLE after mio_ready starts a new transaction (back-to-back allowed); cpu_req dropping mid-transaction is ignored, the access completes.
REQ-031 ram_en, ram_we, io_req, mio_ready and bus_err are 0 in every state not listed above as driving them.

Reset
REQ-032 rst=1 forces, asynchronously: state IDLE, counter 0, all latches 0, cpu_rdata 0, mio_ready 0, bus_err 0, ram_en 0, ram_we 0000, io_req 0.
REQ-033 Reset mid-transaction aborts it with no completion pulse; io_req drops in the same cycle as rst.

Verification
REQ-034 RAM word read at 0x0000_0010, ram_dout=0x1234_5678 -> ram_addr=0x4, mio_ready 3 cycles after request, cpu_rdata=0x1234_5678.
REQ-035 Half-signed read at 0x0000_0012, ram_dout=0x8001_7FFF -> cpu_rdata=0xFFFF_8001; the same access with size 10 -> 0x0000_8001.
REQ-036 Half write at 0x0000_0006, wdata=0x0000_ABCD -> ram_we=1100, ram_din=0xABCD_ABCD, mio_ready 2 cycles after request.
REQ-037 Word read at 0x0000_0002 -> bus_err=1 and mio_ready=1 one cycle later, ram_en never asserted, cpu_rdata=0.
REQ-038 IO read at 0xF000_0000, io_ack after 3 cycles with io_rdata=0xDEAD_BEEF -> cpu_rdata=0xDEAD_BEEF; with no ack, bus_err after TIMEOUT=16 cycles and io_req low.
REQ-039 rst pulsed during IO_REQ -> io_req=0 immediately, state_out=0, no mio_ready; the next request completes normally.
